// File: rtl/mux_bist.sv
// Self-test sequencer for the 2-input, 8-function logic mux: passes manual switches
// through when idle, otherwise sweeps all 32 vectors and checks the mux output.
module mux_bist #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       man_sw0,
    input  logic       man_sw1,
    input  logic [2:0] man_sel,
    input  logic       mux_out,
    output logic       sw0,
    output logic       sw1,
    output logic [2:0] select,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_count,
    output logic       fail_valid,
    output logic [4:0] fail_idx
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_next;
    logic [4:0] v;
    logic [3:0] c;
    logic       launch;
    logic       sample;
    logic       golden;
    logic       miss;

    always_comb begin
        golden = 1'b0;
        case (v[4:2])
            3'b000:  golden = ~v[0];
            3'b001:  golden = v[0];
            3'b010:  golden = ~(v[1] ^ v[0]);
            3'b011:  golden = v[1] ^ v[0];
            3'b100:  golden = v[1] | v[0];
            3'b101:  golden = ~(v[1] | v[0]);
            3'b110:  golden = v[1] & v[0];
            default: golden = ~(v[1] & v[0]);
        endcase
    end

    assign sample = (state == RUN) && (c == SETTLE_C);
    assign miss   = sample && (mux_out != golden);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    launch     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (sample && v == 5'd31) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            v          <= '0;
            c          <= '0;
            err_count  <= '0;
            fail_idx   <= '0;
            fail_valid <= 1'b0;
        end else if (sample) begin
            if (miss) begin
                err_count <= err_count + 6'd1;
                if (!fail_valid) begin
                    fail_idx   <= v;
                    fail_valid <= 1'b1;
                end
            end
            // v stays at 31 after the last compare so DONE keeps driving it
            if (v != 5'd31) v <= v + 5'd1;
            c <= '0;
        end else if (state == RUN) begin
            c <= c + 4'd1;
        end
    end

    always_comb begin
        if (state == IDLE) begin
            sw0    = man_sw0;
            sw1    = man_sw1;
            select = man_sel;
        end else begin
            sw0    = v[0];
            sw1    = v[1];
            select = v[4:2];
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (err_count == 6'd0);

endmodule

// File: tb/tb_mux_bist.sv
// Bench for mux_bist: two instances (SETTLE=0 and SETTLE=1) each driving a behavioural
// mux with selectable fault, checked every cycle against a cycle-count model.
module tb_mux_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, start = 1'b0, man_sw0 = 1'b0, man_sw1 = 1'b0;
    logic [2:0] man_sel = 3'd0;
    int         mode = 0;   // 0 real mux, 1 invert when select==010, 2 stuck at 0
    bit         armed = 1'b0;
    int         vectors = 0, miscompares = 0;

    logic [1:0] mux_o, d_sw0, d_sw1, d_busy, d_done, d_pass, d_fv;
    logic [2:0] d_sel [2];
    logic [5:0] d_err [2];
    logic [4:0] d_fidx[2];

    mux_bist #(.SETTLE(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .man_sw0(man_sw0), .man_sw1(man_sw1),
        .man_sel(man_sel), .mux_out(mux_o[0]), .sw0(d_sw0[0]), .sw1(d_sw1[0]),
        .select(d_sel[0]), .busy(d_busy[0]), .done(d_done[0]), .pass(d_pass[0]),
        .err_count(d_err[0]), .fail_valid(d_fv[0]), .fail_idx(d_fidx[0]));

    mux_bist #(.SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .man_sw0(man_sw0), .man_sw1(man_sw1),
        .man_sel(man_sel), .mux_out(mux_o[1]), .sw0(d_sw0[1]), .sw1(d_sw1[1]),
        .select(d_sel[1]), .busy(d_busy[1]), .done(d_done[1]), .pass(d_pass[1]),
        .err_count(d_err[1]), .fail_valid(d_fv[1]), .fail_idx(d_fidx[1]));

    // Truth table per function, bit index = {sw1,sw0}
    function automatic logic [3:0] truth(input logic [2:0] sel);
        case (sel)
            3'd0: return 4'b0101;  // NOT sw0
            3'd1: return 4'b1010;  // BUF sw0
            3'd2: return 4'b1001;  // XNOR
            3'd3: return 4'b0110;  // XOR
            3'd4: return 4'b1110;  // OR
            3'd5: return 4'b0001;  // NOR
            3'd6: return 4'b1000;  // AND
            default: return 4'b0111;  // NAND
        endcase
    endfunction

    function automatic logic gold(input logic [2:0] sel, input logic s1, input logic s0);
        logic [3:0] tt;
        tt = truth(sel);
        return tt[{s1, s0}];
    endfunction

    function automatic logic fmux(input int md, input logic [2:0] sel, input logic s1, input logic s0);
        if (md == 2) return 1'b0;
        if (md == 1 && sel == 3'b010) return ~gold(sel, s1, s0);
        return gold(sel, s1, s0);
    endfunction

    always_comb begin
        mux_o = '0;
        for (int i = 0; i < 2; i++) mux_o[i] = fmux(mode, d_sel[i], d_sw1[i], d_sw0[i]);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: state 0 idle, 1 run, 2 done; t counts cycles since the sweep launched
    int m_st[2], m_t[2], m_err[2], m_fidx[2];
    bit m_fv[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int per, k;
            logic [4:0] vec;
            per = i + 1;   // instance i has SETTLE = i
            if (rst) begin
                m_st[i] = 0; m_err[i] = 0; m_fidx[i] = 0; m_fv[i] = 0; m_t[i] = 0;
            end else if (m_st[i] != 1 && start) begin
                m_st[i] = 1; m_t[i] = 0; m_err[i] = 0; m_fidx[i] = 0; m_fv[i] = 0;
            end else if (m_st[i] == 1) begin
                k = m_t[i] / per;
                if (m_t[i] % per == per - 1) begin
                    vec = k[4:0];
                    if (fmux(mode, vec[4:2], vec[1], vec[0]) != gold(vec[4:2], vec[1], vec[0])) begin
                        m_err[i]++;
                        if (!m_fv[i]) begin m_fv[i] = 1; m_fidx[i] = k; end
                    end
                    if (k == 31) m_st[i] = 2;
                end
                m_t[i]++;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                logic [4:0] dexp;
                if (m_st[i] == 0)      dexp = {man_sel, man_sw1, man_sw0};
                else if (m_st[i] == 1) dexp = 5'(m_t[i] / (i + 1));
                else                   dexp = 5'd31;
                chk($sformatf("m%0d_drive", i), {d_sel[i], d_sw1[i], d_sw0[i]}, dexp);
                chk($sformatf("m%0d_busy", i), d_busy[i], m_st[i] == 1);
                chk($sformatf("m%0d_done", i), d_done[i], m_st[i] == 2);
                chk($sformatf("m%0d_pass", i), d_pass[i], m_st[i] == 2 && m_err[i] == 0);
                chk($sformatf("m%0d_err", i), d_err[i], m_err[i]);
                chk($sformatf("m%0d_fv", i), d_fv[i], m_fv[i]);
                chk($sformatf("m%0d_fidx", i), d_fidx[i], m_fidx[i]);
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    // Waits for instance i to reach done; counts busy cycles; optional start pulse at cycle pulse_at
    task automatic wait_done(input int i, input int pulse_at, output int busy_cyc);
        bit seen;
        seen = 0;
        busy_cyc = 0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            start = (n == pulse_at);
            if (d_done[i]) seen = 1;
            else if (d_busy[i]) busy_cyc++;
        end
        start = 1'b0;
        if (!seen) chk($sformatf("timeout_u%0d", i), 0, 1);
    endtask

    initial begin
        int bc, run, run_max;
        @(posedge clk); #2 armed = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", d_busy[1], 0);
        chk("rst_err", d_err[1], 0);
        chk("rst_pass", d_pass[1], 0);

        // idle passthrough
        @(posedge clk); #2 man_sel = 3'b110; man_sw0 = 1'b1; man_sw1 = 1'b1;
        @(negedge clk);
        chk("pt_sel", d_sel[1], 3'b110);
        chk("pt_sw0", d_sw0[1], 1);
        chk("pt_sw1", d_sw1[1], 1);

        // clean sweep, extra start at cycle 20 must be ignored
        pulse_start();
        wait_done(1, 20, bc);
        chk("s1_busy_cycles", bc, 64);
        chk("s1_pass", d_pass[1], 1);
        chk("s1_err", d_err[1], 0);
        chk("s1_fv", d_fv[1], 0);

        // XNOR inverted
        @(posedge clk); #2 mode = 1;
        pulse_start();
        wait_done(1, -1, bc);
        chk("x_err", d_err[1], 4);
        chk("x_fidx", d_fidx[1], 8);
        chk("x_fv", d_fv[1], 1);
        chk("x_pass", d_pass[1], 0);
        chk("x_err_u0", d_err[0], 4);

        // restart from DONE with errors
        @(posedge clk); #2 mode = 0;
        pulse_start();
        @(negedge clk);
        chk("clr_err", d_err[1], 0);
        chk("clr_fv", d_fv[1], 0);
        wait_done(1, -1, bc);
        chk("clr_pass", d_pass[1], 1);

        // stuck at 0
        @(posedge clk); #2 mode = 2;
        pulse_start();
        wait_done(0, -1, bc);
        chk("sa0_cycles_u0", bc, 32);
        chk("sa0_err_u0", d_err[0], 16);
        chk("sa0_fidx_u0", d_fidx[0], 0);
        chk("sa0_fv_u0", d_fv[0], 1);
        wait_done(1, -1, bc);
        chk("sa0_err_u1", d_err[1], 16);

        // reset mid-sweep after errors have accrued
        @(posedge clk); #2 mode = 1; man_sel = 3'b101; man_sw0 = 1'b0; man_sw1 = 1'b1;
        pulse_start();
        repeat (19) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("mr_busy", d_busy[0], 0);
        chk("mr_err", d_err[0], 0);
        chk("mr_drive", {d_sel[0], d_sw1[0], d_sw0[0]}, 5'b10110);
        @(posedge clk); #2 mode = 0;
        pulse_start();
        wait_done(1, -1, bc);
        chk("mr_pass", d_pass[1], 1);
        chk("mr_cycles", bc, 64);

        // start held: DONE lasts a single cycle between back-to-back sweeps
        @(posedge clk); #2 start = 1'b1;
        run = 0; run_max = 0;
        repeat (200) begin
            @(negedge clk);
            run = d_done[1] ? run + 1 : 0;
            if (run > run_max) run_max = run;
        end
        chk("held_done_width", run_max, 1);
        @(posedge clk); #2 start = 1'b0;
        repeat (80) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
